// File: rtl/dfd_cla_match_event_counter.sv
// Match event counter for the CLA ones-count match line.
// Optional snapshot output: DFD_CLA_MATCH_CNT_SNAPSHOT_EN.
module dfd_cla_match_event_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 debug_signals_ones_count_match,
    input  logic                 cnt_enable,
    input  logic                 cnt_clear,
    input  logic                 cnt_mode,
    input  logic [CNT_WIDTH-1:0] cnt_threshold,
    input  logic [CNT_WIDTH-1:0] holdoff_cycles,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic                 match_event,
    output logic [1:0]           cnt_state
`ifdef DFD_CLA_MATCH_CNT_SNAPSHOT_EN
    ,
    output logic [CNT_WIDTH-1:0] match_count_snapshot
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        HOLDOFF = 2'b10
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] holdoff_q;
    logic [CNT_WIDTH-1:0] count_inc;
    logic                 event_q;
    logic                 at_max;
    logic                 hit;
    logic                 fire;

    assign at_max    = (count_q == CNT_MAX);
    assign count_inc = count_q + 1'b1;

    // A saturated count never re-fires: only a real increment can hit.
    assign hit = debug_signals_ones_count_match && !at_max
               && (cnt_threshold != '0)
               && (count_inc == cnt_threshold);

    assign fire = (state_q == ARMED) && cnt_enable && !cnt_clear && hit;

    // Main FSM: enable > clear > fire > mode-dependent count update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            holdoff_q <= '0;
            event_q   <= 1'b0;
        end else if (!cnt_enable) begin
            state_q   <= IDLE;
            count_q   <= '0;
            holdoff_q <= '0;
            event_q   <= 1'b0;
        end else if (cnt_clear) begin
            state_q   <= ARMED;
            count_q   <= '0;
            holdoff_q <= '0;
            event_q   <= 1'b0;
        end else begin
            event_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q <= ARMED;
                    count_q <= '0;
                end
                ARMED: begin
                    if (hit) begin
                        state_q   <= HOLDOFF;
                        count_q   <= count_inc;
                        holdoff_q <= holdoff_cycles;
                        event_q   <= 1'b1;
                    end else if (debug_signals_ones_count_match) begin
                        if (!at_max)
                            count_q <= count_inc;
                    end else if (cnt_mode) begin
                        count_q <= '0;
                    end
                end
                HOLDOFF: begin
                    if (holdoff_q == '0) begin
                        state_q <= ARMED;
                        count_q <= '0;
                    end else begin
                        holdoff_q <= holdoff_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    count_q   <= '0;
                    holdoff_q <= '0;
                end
            endcase
        end
    end

`ifdef DFD_CLA_MATCH_CNT_SNAPSHOT_EN
    logic [CNT_WIDTH-1:0] snap_q;

    // Capture the firing count; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset)
            snap_q <= '0;
        else if (fire)
            snap_q <= count_inc;
    end

    assign match_count_snapshot = snap_q;
`endif

    assign match_count = count_q;
    assign match_event = event_q;
    assign cnt_state   = state_q;

endmodule

// File: tb/tb_dfd_cla_match_event_counter.sv
// Bench for dfd_cla_match_event_counter: vector table,
// directed corner sequences and random stimulus vs a model.
module tb_dfd_cla_match_event_counter;

    logic        clock = 1'b0;
    logic        reset;
    logic        match;
    logic        cnt_enable;
    logic        cnt_clear;
    logic        cnt_mode;
    logic [15:0] cnt_threshold;
    logic [15:0] holdoff_cycles;
    logic [15:0] match_count;
    logic        match_event;
    logic [1:0]  cnt_state;
    logic [3:0]  s_count;
    logic        s_event;
    logic [1:0]  s_state;
`ifdef DFD_CLA_MATCH_CNT_SNAPSHOT_EN
    logic [15:0] snapshot;
    logic [3:0]  s_snapshot;
`endif

    always #5 clock = ~clock;

    dfd_cla_match_event_counter #(.CNT_WIDTH(16)) dut (
        .clock                          (clock),
        .reset                          (reset),
        .debug_signals_ones_count_match (match),
        .cnt_enable                     (cnt_enable),
        .cnt_clear                      (cnt_clear),
        .cnt_mode                       (cnt_mode),
        .cnt_threshold                  (cnt_threshold),
        .holdoff_cycles                 (holdoff_cycles),
        .match_count                    (match_count),
        .match_event                    (match_event),
        .cnt_state                      (cnt_state)
`ifdef DFD_CLA_MATCH_CNT_SNAPSHOT_EN
        ,
        .match_count_snapshot           (snapshot)
`endif
    );

    dfd_cla_match_event_counter #(.CNT_WIDTH(4)) dut4 (
        .clock                          (clock),
        .reset                          (reset),
        .debug_signals_ones_count_match (match),
        .cnt_enable                     (cnt_enable),
        .cnt_clear                      (cnt_clear),
        .cnt_mode                       (cnt_mode),
        .cnt_threshold                  (cnt_threshold[3:0]),
        .holdoff_cycles                 (holdoff_cycles[3:0]),
        .match_count                    (s_count),
        .match_event                    (s_event),
        .cnt_state                      (s_state)
`ifdef DFD_CLA_MATCH_CNT_SNAPSHOT_EN
        ,
        .match_count_snapshot           (s_snapshot)
`endif
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        clr;
        logic        mode;
        logic [15:0] thr;
        logic [15:0] ho;
        logic        m;
        logic [15:0] ecnt;
        logic        eevt;
        logic [1:0]  est;
    } vec_t;

    vec_t vt[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: state 0 idle, 1 armed, 2 holdoff.
    // left = holdoff cycles still to spend, including the current one.
    int     m_st;
    longint m_cnt;
    int     m_left;
    bit     m_evt;
    longint m_snap;
    longint m_max = 65535;

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, en, clr, mode,
                              input longint thr, ho, input bit m);
        if (rst) begin
            m_st = 0; m_cnt = 0; m_left = 0; m_evt = 0; m_snap = 0;
        end else if (!en) begin
            m_st = 0; m_cnt = 0; m_left = 0; m_evt = 0;
        end else if (clr) begin
            m_st = 1; m_cnt = 0; m_left = 0; m_evt = 0;
        end else if (m_st == 0) begin
            m_st = 1; m_cnt = 0; m_evt = 0;
        end else if (m_st == 1) begin
            m_evt = 0;
            if (m && m_cnt < m_max) begin
                m_cnt = m_cnt + 1;
                if (thr != 0 && m_cnt == thr) begin
                    m_evt = 1;
                    m_st = 2;
                    m_left = int'(ho) + 1;
                    m_snap = m_cnt;
                end
            end else if (!m && mode) begin
                m_cnt = 0;
            end
        end else begin
            m_evt = 0;
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_st = 1;
                m_cnt = 0;
            end
        end
    endtask

    task automatic step(input bit rst, en, clr, mode,
                        input logic [15:0] thr, ho, input bit m);
        @(negedge clock);
        reset          = rst;
        cnt_enable     = en;
        cnt_clear      = clr;
        cnt_mode       = mode;
        cnt_threshold  = thr;
        holdoff_cycles = ho;
        match          = m;
        @(posedge clock);
        model_edge(rst, en, clr, mode, longint'(thr), longint'(ho), m);
        #1;
        check("model_count", longint'(match_count), m_cnt);
        check("model_event", longint'(match_event), longint'(m_evt));
        check("model_state", longint'(cnt_state), longint'(m_st));
`ifdef DFD_CLA_MATCH_CNT_SNAPSHOT_EN
        check("model_snapshot", longint'(snapshot), m_snap);
`endif
    endtask

    task automatic row(input int rst, en, clr, mode, thr, ho, m,
                       input int cnt, evt, st);
        vec_t v;
        v.rst  = rst[0];
        v.en   = en[0];
        v.clr  = clr[0];
        v.mode = mode[0];
        v.thr  = 16'(thr);
        v.ho   = 16'(ho);
        v.m    = m[0];
        v.ecnt = 16'(cnt);
        v.eevt = evt[0];
        v.est  = st[1:0];
        vt.push_back(v);
    endtask

    initial begin
        reset = 1'b1; cnt_enable = 1'b0; cnt_clear = 1'b0;
        cnt_mode = 1'b0; cnt_threshold = '0; holdoff_cycles = '0;
        match = 1'b0;
        m_st = 0; m_cnt = 0; m_left = 0; m_evt = 0; m_snap = 0;

        //   rst en clr md thr ho m   cnt evt st
        row(1, 0, 0, 0, 3, 2, 0,  0, 0, 0);
        row(0, 1, 0, 0, 3, 2, 0,  0, 0, 1);
        row(0, 1, 0, 0, 3, 2, 1,  1, 0, 1);
        row(0, 1, 0, 0, 3, 2, 0,  1, 0, 1);
        row(0, 1, 0, 0, 3, 2, 1,  2, 0, 1);
        row(0, 1, 0, 0, 3, 2, 1,  3, 1, 2);
        row(0, 1, 0, 0, 3, 2, 1,  3, 0, 2);
        row(0, 1, 0, 0, 3, 2, 1,  3, 0, 2);
        row(0, 1, 0, 0, 3, 2, 0,  0, 0, 1);
        row(0, 1, 0, 1, 3, 2, 1,  1, 0, 1);
        row(0, 1, 0, 1, 3, 2, 1,  2, 0, 1);
        row(0, 1, 0, 1, 3, 2, 0,  0, 0, 1);
        row(0, 1, 0, 1, 3, 2, 1,  1, 0, 1);
        row(0, 1, 0, 1, 3, 2, 1,  2, 0, 1);
        row(0, 1, 0, 1, 3, 2, 1,  3, 1, 2);
        row(0, 1, 0, 1, 3, 2, 0,  3, 0, 2);
        row(0, 1, 0, 1, 3, 2, 0,  3, 0, 2);
        row(0, 1, 0, 1, 3, 2, 0,  0, 0, 1);
        row(0, 1, 0, 0, 2, 0, 1,  1, 0, 1);
        row(0, 1, 1, 0, 2, 0, 1,  0, 0, 1);
        row(0, 1, 0, 0, 2, 0, 1,  1, 0, 1);
        row(0, 1, 0, 0, 2, 0, 1,  2, 1, 2);
        row(0, 0, 0, 0, 2, 0, 1,  0, 0, 0);
        row(0, 1, 0, 0, 1, 5, 0,  0, 0, 1);
        row(0, 1, 0, 0, 1, 5, 1,  1, 1, 2);
        row(0, 1, 0, 0, 1, 5, 0,  1, 0, 2);
        row(1, 1, 0, 0, 1, 5, 1,  0, 0, 0);
        row(0, 1, 0, 0, 1, 0, 1,  0, 0, 1);
        row(0, 1, 0, 0, 1, 0, 1,  1, 1, 2);
        row(0, 1, 0, 0, 1, 0, 1,  0, 0, 1);
        row(0, 1, 0, 0, 5, 0, 1,  1, 0, 1);
        row(0, 1, 0, 0, 5, 0, 1,  2, 0, 1);
        row(0, 1, 0, 0, 5, 0, 1,  3, 0, 1);
        row(0, 1, 0, 0, 2, 0, 0,  3, 0, 1);
        row(0, 1, 0, 0, 2, 0, 1,  4, 0, 1);

        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].en, vt[i].clr, vt[i].mode,
                 vt[i].thr, vt[i].ho, vt[i].m);
            check($sformatf("vec%0d_count", i),
                  longint'(match_count), longint'(vt[i].ecnt));
            check($sformatf("vec%0d_event", i),
                  longint'(match_event), longint'(vt[i].eevt));
            check($sformatf("vec%0d_state", i),
                  longint'(cnt_state), longint'(vt[i].est));
        end

        // Threshold 0 never fires; narrow counter saturates.
        step(1, 0, 0, 0, 16'd0, 16'd0, 0);
        step(0, 1, 0, 0, 16'd0, 16'd0, 0);
        for (int i = 0; i < 20; i++)
            step(0, 1, 0, 0, 16'd0, 16'd0, 1);
        check("thr0_count", longint'(match_count), 20);
        check("thr0_event", longint'(match_event), 0);
        check("sat4_count", longint'(s_count), 15);
        check("sat4_event", longint'(s_event), 0);
        check("sat4_state", longint'(s_state), 1);

        // Fire at 7, re-arm, partial count: snapshot keeps 7.
        step(1, 0, 0, 0, 16'd7, 16'd1, 0);
        step(0, 1, 0, 0, 16'd7, 16'd1, 0);
        for (int i = 0; i < 7; i++)
            step(0, 1, 0, 0, 16'd7, 16'd1, 1);
        check("fire7_event", longint'(match_event), 1);
        for (int i = 0; i < 5; i++)
            step(0, 1, 0, 0, 16'd7, 16'd1, 1);
        check("rearm_count", longint'(match_count), 3);
`ifdef DFD_CLA_MATCH_CNT_SNAPSHOT_EN
        check("snap_held", longint'(snapshot), 7);
`endif

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            bit          r_rst, r_en, r_clr, r_mode, r_m;
            logic [15:0] r_thr, r_ho;
            r_rst  = ($urandom_range(0, 99) == 0);
            r_en   = ($urandom_range(0, 29) != 0);
            r_clr  = ($urandom_range(0, 39) == 0);
            r_mode = ($urandom_range(0, 199) == 0) ? ~cnt_mode
                                                   : cnt_mode;
            r_thr  = ($urandom_range(0, 49) == 0)
                     ? 16'($urandom_range(0, 6)) : cnt_threshold;
            r_ho   = 16'($urandom_range(0, 4));
            r_m    = ($urandom_range(0, 9) < 7);
            step(r_rst, r_en, r_clr, r_mode, r_thr, r_ho, r_m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
